// File: rtl/shreg_pkg.sv
// shreg_pkg: mode encoding shared by the universal shift register
package shreg_pkg;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_HOLD = 2'b00;
    localparam mode_t MODE_SHR  = 2'b01;
    localparam mode_t MODE_SHL  = 2'b10;
    localparam mode_t MODE_LOAD = 2'b11;
endpackage

// File: rtl/shreg_bit_cnt.sv
// shreg_bit_cnt: shift counter that pulses done on the edge completing a WIDTH-bit word
module shreg_bit_cnt #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= inc && cnt == LAST;
            cnt  <= clr ? '0 : !inc ? cnt : (cnt == LAST) ? '0 : cnt + 1'b1;
        end
endmodule

// File: rtl/shreg_univ.sv
// shreg_univ: WIDTH-bit universal shift register (hold / shift right / shift left / load)
// Define SHREG_WORD_DONE_EN to add the bit counter and word_done pulse.
module shreg_univ
    import shreg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout_r,
    output logic             sout_l,
    output logic             word_done
);
    mode_t m;
    logic [WIDTH-1:0] q, q_nxt;
    assign m = en ? mode : MODE_HOLD;
    always_comb
        q_nxt = (m == MODE_SHR)  ? {sin_r, q[WIDTH-1:1]} :
                (m == MODE_SHL)  ? {q[WIDTH-2:0], sin_l} :
                (m == MODE_LOAD) ? pin : q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) q <= '0;
        else q <= q_nxt;
    assign pout   = q;
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
`ifdef SHREG_WORD_DONE_EN
    shreg_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (m == MODE_LOAD),
        .inc  (m == MODE_SHR || m == MODE_SHL),
        .done (word_done)
    );
`else
    assign word_done = 1'b0;
`endif
endmodule

// File: doc/shreg_univ.md
# shreg_univ

Parametrised universal shift register, WIDTH bits wide, selectable per cycle between hold, shift-right, shift-left and parallel load. It generalises the fixed 4-bit serial-in/serial-out register to SISO, SIPO, PISO and PIPO use from one block. An optional bit counter flags each completed word of WIDTH shifts. It sits between serial links and word-wide datapaths in the memories area.

## Interface
- WIDTH, 4, register length in bits; legal range 2..64
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  clock enable; 0 forces hold regardless of mode
- mode  in  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
- sin_r  in  1  serial input, enters at bit WIDTH-1 on shift right
- sin_l  in  1  serial input, enters at bit 0 on shift left
- pin  in  WIDTH  parallel load data
- pout  out  WIDTH  register contents q
- sout_r  out  1  q[0], serial output for shift right
- sout_l  out  1  q[WIDTH-1], serial output for shift left
- word_done  out  1  one-cycle pulse after WIDTH shifts (SHREG_WORD_DONE_EN only)

## Operation
- Reset (rst=0): q=0, bit count=0, word_done=0, so pout=0, sout_r=0, sout_l=0; takes effect immediately, independent of clk.
- On each rising clk with rst=1:
  - en=0 or mode=00: q, count unchanged; word_done=0.
  - mode=01: q <= {sin_r, q[WIDTH-1:1]}.
  - mode=10: q <= {q[WIDTH-2:0], sin_l}.
  - mode=11: q <= pin; count <= 0; word_done=0.
- All outputs are direct register taps; no combinational path from inputs to outputs.
- Bit counter (CNT_W = clog2(WIDTH) bits): increments on every shift in either direction; wraps WIDTH-1 -> 0. The edge performing the wrap sets word_done=1 for exactly one cycle; any other edge clears it.
- Direction changes mid-word do not reset the count; only reset and parallel load clear it.
- Shift and load are mutually exclusive by encoding; no simultaneous-event arbitration needed.
- Reset asserted mid-word discards partial word; no word_done is issued for it.

## Timing
- Shift latency: bit presented on sin_r at edge n appears on sout_r after edge n+WIDTH-1, i.e. WIDTH edges from input to full traversal (WIDTH=4: sin sampled at edge 1 visible on sout_r after edge 4).
- Parallel load: pout = pin one edge after mode=11.
- word_done: high in the cycle following the WIDTH-th shift edge since last load/reset, low the next cycle unless another wrap occurs (only possible for back-to-back words, WIDTH shifts apart).
- Reset deassertion: first active edge is the first clk rise with rst=1.

## Configuration
- SHREG_WORD_DONE_EN defined: bit counter and word_done implemented as above.
- Undefined: no counter flops; word_done tied to 0; all other behaviour identical.

## Structure
- Package shreg_pkg: mode encoding constants (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD) and the 2-bit mode type.
- One sub-module: shreg_bit_cnt (counter with clear, increment, wrap pulse), instantiated only under SHREG_WORD_DONE_EN.

## Test plan
- Reset: rst=0 with q previously 4'hF -> pout=0, sout_r=0, word_done=0 before next clk edge.
- SISO, WIDTH=4: mode=01, sin_r = 1,1,0,0,1,1 on successive edges -> sout_r = 1,1,0,0 after edges 4..7; word_done pulses after edge 4.
- PISO, WIDTH=8: load pin=8'hA5, then 8 shift-left edges with sin_l=0 -> sout_l sequence 1,0,1,0,0,1,0,1 before each shift; pout=0 at end; word_done high after 8th shift.
- SIPO/hold: shift right 4'b1011 into WIDTH=4, then en=0 for 3 cycles with mode=01 -> pout stays 4'b1011, no word_done.
- Mid-word load/reset: 2 shifts, load pin=4'h3, 4 more shifts -> word_done after 4th post-load shift only; rst pulse after 3 shifts -> q=0, count restarts, no pulse.
- Macro off: repeat SISO case -> word_done constantly 0, data identical.
